// File: rtl/divider_16bit.sv
// Sequential 16-bit restoring divider with start/done handshake, 16 steps per operation.
// Define DIVIDER_16BIT_SIGNED_EN for two's-complement operands (truncation toward zero).
module divider_16bit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] q,
   output logic [15:0] r,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [16:0] p;
   logic [15:0] d;
   logic [15:0] yr;

   logic [16:0] p_shift;
   logic [16:0] diff;
   logic [16:0] p_step;
   logic        qbit;
   logic [15:0] q_raw;
   logic [15:0] q_fix;
   logic [15:0] r_fix;
   logic [15:0] x_mag;
   logic [15:0] y_mag;

`ifdef DIVIDER_16BIT_SIGNED_EN
   logic neg_q;
   logic neg_r;

   // operand magnitudes and sign fix-up of the final step
   always_comb begin
      x_mag = x[15] ? (16'd0 - x) : x;
      y_mag = y[15] ? (16'd0 - y) : y;
      q_fix = neg_q ? (16'd0 - q_raw) : q_raw;
      r_fix = neg_r ? (16'd0 - p_step[15:0]) : p_step[15:0];
   end
`else
   // unsigned build: operands and results pass straight through
   always_comb begin
      x_mag = x;
      y_mag = y;
      q_fix = q_raw;
      r_fix = p_step[15:0];
   end
`endif

   // one restoring step: the borrow out of the 17-bit subtract decides restore
   always_comb begin
      p_shift = {p[15:0], d[15]};
      diff    = p_shift - {1'b0, yr};
      if (!diff[16]) begin
         p_step = diff;
         qbit   = 1'b1;
      end else begin
         p_step = p_shift;
         qbit   = 1'b0;
      end
      q_raw = {d[14:0], qbit};
   end

   // control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         p        <= 17'd0;
         d        <= 16'd0;
         yr       <= 16'd0;
         q        <= 16'd0;
         r        <= 16'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
`ifdef DIVIDER_16BIT_SIGNED_EN
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  if (y == 16'd0) begin
                     q        <= 16'hFFFF;
                     r        <= x;
                     div_zero <= 1'b1;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     p     <= 17'd0;
                     d     <= x_mag;
                     yr    <= y_mag;
                     cnt   <= 4'd0;
                     busy  <= 1'b1;
                     state <= RUN;
`ifdef DIVIDER_16BIT_SIGNED_EN
                     neg_q <= x[15] ^ y[15];
                     neg_r <= x[15];
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               p   <= p_step;
               d   <= q_raw;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  q        <= q_fix;
                  r        <= r_fix;
                  div_zero <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_16bit.sv
// Self-checking bench for divider_16bit: vector table, corner sequences, random ops vs. model.
module tb_divider_16bit;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] eq;
      logic [15:0] er;
      logic        edz;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] q;
   logic [15:0] r;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int failures = 0;

   divider_16bit dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
      .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: plain integer division following the operand interpretation of the build
   function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
      vec_t v;
      int sa, sb;
      v.a = a;
      v.b = b;
      if (b == 16'd0) begin
         v.eq = 16'hFFFF; v.er = a; v.edz = 1'b1;
      end else begin
`ifdef DIVIDER_16BIT_SIGNED_EN
         sa = int'($signed(a));
         sb = int'($signed(b));
`else
         sa = int'({16'd0, a});
         sb = int'({16'd0, b});
`endif
         v.eq = 16'(sa / sb);
         v.er = 16'(sa % sb);
         v.edz = 1'b0;
      end
      return v;
   endfunction

   // one operation from IDLE/DONE: checks latency, busy length, results and done width
   task automatic do_op(input vec_t v, input string nm);
      int n;
      int bc;
      @(negedge clk);
      x = v.a; y = v.b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x = $urandom; y = $urandom;
      n = 1; bc = 0;
      while (!done && n < 40) begin
         if (busy) bc++;
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, n, v.edz ? 1 : 17);
      chk({nm, " busy_cycles"}, bc, v.edz ? 0 : 16);
      chk({nm, " busy_with_done"}, {31'd0, busy}, 32'd0);
      chk({nm, " q"}, {16'd0, q}, {16'd0, v.eq});
      chk({nm, " r"}, {16'd0, r}, {16'd0, v.er});
      chk({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, v.edz});
      @(negedge clk);
      chk({nm, " done_width"}, {31'd0, done}, 32'd0);
      chk({nm, " q_hold"}, {16'd0, q}, {16'd0, v.eq});
   endtask

   vec_t tbl[8];
   vec_t v;
   int   n;
   int   n2;

   initial begin
`ifdef DIVIDER_16BIT_SIGNED_EN
      tbl[0] = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0};
      tbl[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
      tbl[2] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
      tbl[3] = '{16'h1234, 16'd0,    16'hFFFF, 16'h1234, 1'b1};
      tbl[4] = '{16'd7,    16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
      tbl[5] = '{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0};
      tbl[6] = '{16'd16,   16'd16,   16'd1,    16'd0,    1'b0};
      tbl[7] = '{16'h8000, 16'd0,    16'hFFFF, 16'h8000, 1'b1};
`else
      tbl[0] = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
      tbl[1] = '{16'h1234,  16'd0,     16'hFFFF,  16'h1234,  1'b1};
      tbl[2] = '{16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0};
      tbl[3] = '{16'd16,    16'd16,    16'd1,     16'd0,     1'b0};
      tbl[4] = '{16'd5,     16'd10,    16'd0,     16'd5,     1'b0};
      tbl[5] = '{16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0};
      tbl[6] = '{16'd65535, 16'd2,     16'd32767, 16'd1,     1'b0};
      tbl[7] = '{16'd1,     16'd65535, 16'd0,     16'd1,     1'b0};
`endif
      reset = 1'b1; start = 1'b0; x = 16'd0; y = 16'd0;
      @(negedge clk);
      chk("reset q", {16'd0, q}, 32'd0);
      chk("reset r", {16'd0, r}, 32'd0);
      chk("reset flags", {29'd0, busy, done, div_zero}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) do_op(tbl[i], $sformatf("vec%0d", i));

      // start with new operands during RUN must not disturb the running 50/5
      @(negedge clk);
      x = 16'd50; y = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      x = 16'd7; y = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 6;
      while (!done && n < 40) begin @(negedge clk); n++; end
      chk("ignore latency", n, 17);
      chk("ignore q", {16'd0, q}, 32'd10);
      chk("ignore r", {16'd0, r}, 32'd0);
      @(negedge clk);
      chk("ignore no_restart", {30'd0, busy, done}, 32'd0);

      // back-to-back with start held high
      @(negedge clk);
      x = 16'd65535; y = 16'd1; start = 1'b1;
      @(negedge clk);
      x = 16'd16; y = 16'd16;
      n = 1;
      while (!done && n < 40) begin @(negedge clk); n++; end
      v = model(16'd65535, 16'd1);
      chk("b2b first latency", n, 17);
      chk("b2b first q", {16'd0, q}, {16'd0, v.eq});
      chk("b2b first r", {16'd0, r}, {16'd0, v.er});
      @(negedge clk);
      start = 1'b0;
      chk("b2b rerun busy", {31'd0, busy}, 32'd1);
      n2 = 1;
      while (!done && n2 < 40) begin @(negedge clk); n2++; end
      chk("b2b spacing", n2, 17);
      chk("b2b second q", {16'd0, q}, 32'd1);
      chk("b2b second r", {16'd0, r}, 32'd0);

      // reset in the middle of an operation
      @(negedge clk);
      x = 16'd100; y = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset q", {16'd0, q}, 32'd0);
      chk("midreset r", {16'd0, r}, 32'd0);
      chk("midreset flags", {29'd0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) n++;
      end
      chk("midreset no_done", n, 0);
      do_op(model(16'd1000, 16'd33), "after_reset");

      // random operations against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         case (i % 4)
            0: b = 16'($urandom_range(1, 15));
            1: b = 16'($urandom);
            2: b = (i % 8 == 2) ? 16'd0 : 16'($urandom_range(1, 300));
            default: b = 16'($urandom);
         endcase
         do_op(model(a, b), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
